uart_echo_buffer: RTL and testbench
===================================

UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 Parameter DATA_W, default 8, meaning character width in bits.
REQ-002 Parameter DEPTH, default 16, meaning echo FIFO depth; it SHALL be a power of two, 2..256.
REQ-003 Parameter BANNER_EN, default 1, meaning that when it is 1 the banner "Hello World!" (12 bytes) SHALL be sent after reset.
REQ-004 Parameter LINE_MODE, default 0, meaning 0 = per-character echo and 1 = echo held until line terminator 0x0D.
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- rx_data  in  DATA_W  received character
- rx_error  in  1  one-cycle strobe; framing error, no data
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  DATA_W  character to transmit; stable while tx_start is high and until tx_busy falls
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a received character was dropped
- err_count  out  8  saturating count of rx_error strobes

Function
REQ-006 Each rx_valid SHALL push rx_data into the FIFO in the same cycle, unless the FIFO is full.
REQ-007 A push into a full FIFO SHALL drop the character and set overflow; FIFO contents SHALL be unchanged.
REQ-008 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full (push then accepted) or empty (pop impossible, push only).
REQ-009 rx_error SHALL increment err_count, saturating at 255; it SHALL push nothing.
REQ-010 The FSM SHALL have the states BANNER, IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-011 After reset the FSM SHALL enter BANNER if BANNER_EN=1, else IDLE.
REQ-012 In BANNER the FSM SHALL transmit banner bytes 0..11 in order, each via START/WAIT_BUSY/WAIT_DONE, then go to IDLE; received characters SHALL still be buffered.
REQ-013 In IDLE with LINE_MODE=0, the FSM SHALL go to START when the FIFO is non-empty.
REQ-014 In IDLE with LINE_MODE=1, the FSM SHALL go to START when pending_lines>0 or the flush flag is set.
REQ-015 Entry to START SHALL pop the FIFO head into tx_data.
REQ-016 START SHALL only be entered while tx_busy=0.
REQ-017 START SHALL assert tx_start for exactly one cycle, then go to WAIT_BUSY.
REQ-018 WAIT_BUSY SHALL advance to WAIT_DONE on tx_busy=1.
REQ-019 WAIT_DONE SHALL return to IDLE, or to the next banner byte, on tx_busy=0.
REQ-020 Latency SHALL be: rx_valid into an empty FIFO with transmitter idle (LINE_MODE=0, post-banner) to tx_start = 2 cycles.
REQ-021 pending_lines SHALL increment when 0x0D is pushed and decrement when 0x0D is popped; a simultaneous increment and decrement SHALL leave it unchanged; width SHALL be $clog2(DEPTH)+1.
REQ-022 In LINE_MODE=1 a full FIFO with pending_lines=0 SHALL set the flush flag; the flag SHALL clear when the FIFO becomes empty.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-024 In LINE_MODE=0, pending_lines and the flush flag SHALL be held at 0.

Reset
REQ-025 rst SHALL set tx_start=0, tx_data=0, fifo_count=0, overflow=0, err_count=0, pending_lines=0, flush=0, FIFO pointers=0 and banner index=0, and SHALL set the state per REQ-011.
REQ-026 rst asserted mid-transmission SHALL abandon the current character, discard FIFO contents and restart the banner; tx_start SHALL be 0 in the cycle following rst.

Structure
REQ-027 Package uart_echo_pkg SHALL hold the FSM state encoding, the LINE_TERM constant 0x0D, the BANNER_LEN constant 12 and the banner byte table.
REQ-028 The FIFO SHALL be the sub-module echo_fifo (parameters DATA_W and DEPTH; ports push, pop, din, dout, full, empty, count), with synchronous reset.

Verification
REQ-029 BANNER_EN=1, UART model with tx_busy high for 10 cycles per byte -> tx_data sequence 0x48 65 6C 6C 6F 20 57 6F 72 6C 64 21, one tx_start each.
REQ-030 BANNER_EN=0, LINE_MODE=0, rx "A" (0x41) -> tx_start 2 cycles later with tx_data=0x41; fifo_count returns to 0.
REQ-031 DEPTH=4, tx_busy held high, 6 rx_valid strobes 0x31..0x36 -> fifo_count=4, overflow=1, then echo 0x31..0x34 only.
REQ-032 LINE_MODE=1, rx "ab" -> no tx_start for 100 cycles; rx 0x0D -> echo 0x61 0x62 0x0D, then pending_lines=0.
REQ-033 LINE_MODE=1, DEPTH=4, rx 4 characters with no 0x0D -> flush; all 4 are echoed and flush clears.
REQ-034 300 rx_error strobes -> err_count=255; rst asserted during the banner byte "l" -> banner restarts at 0x48, overflow=0.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: FSM encoding, line terminator and banner table shared by the echo buffer.
package uart_echo_pkg;
    typedef enum logic [2:0] {S_BANNER, S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_e;
    localparam logic [7:0] LINE_TERM = 8'h0D;
    localparam int BANNER_LEN = 12;
    localparam logic [8*BANNER_LEN-1:0] BANNER_TEXT = "Hello World!";
    // Byte 0 is the leftmost character, which sits in the top byte of the literal.
    function automatic logic [7:0] banner_byte(input logic [3:0] idx);
        return BANNER_TEXT[8*(BANNER_LEN-1-int'(idx)) +: 8];
    endfunction
endpackage

// File: rtl/echo_fifo.sv
// echo_fifo: power-of-two circular buffer with show-ahead head, push accepted when full if popping.
module echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: buffers received characters and echoes them to a UART transmitter,
// optionally after a power-on banner and optionally held back until a full line arrives.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int BANNER_EN = 1,
    parameter int LINE_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_error,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             err_count
);
    localparam bit LM = LINE_MODE != 0;
    state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic banner_q, banner_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, dout;
    logic [$clog2(DEPTH):0] pend_q, pend_d;
    logic flush_q, flush_d, ovf_q, ovf_d;
    logic [7:0] err_q, err_d;
    logic full, empty, pop, push_ok, go, inc, dec;

    echo_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(rx_valid), .pop(pop), .din(rx_data),
        .dout(dout), .full(full), .empty(empty), .count(fifo_count)
    );

    assign push_ok = rx_valid && (!full || pop);
    assign inc     = LM && push_ok && rx_data == DATA_W'(LINE_TERM);
    assign dec     = LM && pop && dout == DATA_W'(LINE_TERM);
    assign go      = !empty && (!LM || pend_q != '0 || flush_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        banner_d  = banner_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            S_BANNER: if (!tx_busy) begin
                state_d   = S_START;
                tx_data_d = DATA_W'(banner_byte(idx_q));
            end
            S_IDLE: if (go && !tx_busy) begin
                state_d   = S_START;
                tx_data_d = dout;
                pop       = 1'b1;
            end
            S_START:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: state_d = tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
            S_WAIT_DONE: if (!tx_busy) begin
                if (banner_q && idx_q != 4'(BANNER_LEN - 1)) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_BANNER;
                end else begin
                    banner_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flush drains a line-less full buffer completely before line gating resumes.
    always_comb begin
        pend_d  = (inc && !dec) ? pend_q + 1'b1 : (dec && !inc) ? pend_q - 1'b1 : pend_q;
        flush_d = LM && (flush_q ? !empty : (full && pend_q == '0));
        ovf_d   = ovf_q || (rx_valid && !push_ok);
        err_d   = (rx_error && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (BANNER_EN != 0) ? S_BANNER : S_IDLE;
            banner_q  <= BANNER_EN != 0;
            idx_q     <= '0;
            tx_data_q <= '0;
            pend_q    <= '0;
            flush_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            banner_q  <= banner_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            pend_q    <= pend_d;
            flush_q   <= flush_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign tx_start  = state_q == S_START;
    assign tx_data   = tx_data_q;
    assign overflow  = ovf_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: three configurations (banner, per-character DEPTH=4, line mode DEPTH=4)
// with a busy-for-10-cycles UART model and an expected-echo queue per instance.
module tb_uart_echo_buffer;
    typedef struct {
        logic [7:0] ch;
        int         lat;
        int         fc_after;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst, rxv, rxe, hold, busy, txs, ovf;
    logic [7:0] rxd [3];
    logic [7:0] txd [3];
    logic [7:0] errc [3];
    logic [4:0] fcw [3];
    logic [7:0] expq [3][$];
    logic [7:0] ban [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    int n_cmp = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DP = (g == 0) ? 16 : 4;
        logic [$clog2(DP):0] fc;
        int bc = 0;
        uart_echo_buffer #(.DATA_W(8), .DEPTH(DP), .BANNER_EN(g == 0 ? 1 : 0), .LINE_MODE(g == 2 ? 1 : 0)) dut (
            .clk(clk), .rst(rst[g]), .rx_valid(rxv[g]), .rx_data(rxd[g]), .rx_error(rxe[g]),
            .tx_busy(busy[g]), .tx_start(txs[g]), .tx_data(txd[g]), .fifo_count(fc),
            .overflow(ovf[g]), .err_count(errc[g])
        );
        always @(posedge clk) bc <= txs[g] ? 10 : (bc != 0 ? bc - 1 : 0);
        assign busy[g] = hold[g] || bc != 0;
        assign fcw[g]  = 5'(fc);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx(input int g, input logic [7:0] d);
        rxv[g] = 1'b1;
        rxd[g] = d;
        tick();
        rxv[g] = 1'b0;
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) if (txs[g]) begin
                n_cmp++;
                if (expq[g].size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_dut%0d: got %02h expected no transmission", g, txd[g]);
                end else begin
                    e = expq[g].pop_front();
                    if (txd[g] !== e) begin
                        n_fail++;
                        $display("FAIL tx_dut%0d: got %02h expected %02h", g, txd[g], e);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int g, input int budget);
        int n = 0;
        while (expq[g].size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("drain%0d", g), expq[g].size(), 0);
        repeat (15) tick();
    endtask

    initial begin
        vec_t vt [6];
        int lat, n;
        vt[0] = '{8'h41, 2, 0};
        vt[1] = '{8'h00, 2, 0};
        vt[2] = '{8'hFF, 2, 0};
        vt[3] = '{8'h0D, 2, 0};
        vt[4] = '{8'h7F, 2, 0};
        vt[5] = '{8'h80, 2, 0};
        rst = 3'b111; rxv = '0; rxe = '0; hold = '0;
        for (int g = 0; g < 3; g++) rxd[g] = '0;
        fork monitor(); join_none
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_txs%0d", g), int'(txs[g]), 0);
            check($sformatf("rst_txd%0d", g), int'(txd[g]), 0);
            check($sformatf("rst_cnt%0d", g), int'(fcw[g]), 0);
            check($sformatf("rst_ovf%0d", g), int'(ovf[g]), 0);
            check($sformatf("rst_err%0d", g), int'(errc[g]), 0);
        end
        for (int i = 0; i < 12; i++) expq[0].push_back(ban[i]);
        rst = '0;

        // per-character echo latency, table driven
        for (int i = 0; i < 6; i++) begin
            expq[1].push_back(vt[i].ch);
            rx(1, vt[i].ch);
            lat = 1;
            while (!txs[1] && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("lat_%02h", vt[i].ch), lat, vt[i].lat);
            check($sformatf("txd_%02h", vt[i].ch), int'(txd[1]), int'(vt[i].ch));
            repeat (14) tick();
            check($sformatf("cnt_%02h", vt[i].ch), int'(fcw[1]), vt[i].fc_after);
        end

        // full FIFO accepts a push in the same cycle as a pop
        hold[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expq[1].push_back(8'(8'h31 + i));
            rx(1, 8'(8'h31 + i));
        end
        check("full_cnt", int'(fcw[1]), 4);
        check("full_ovf", int'(ovf[1]), 0);
        expq[1].push_back(8'h35);
        hold[1] = 1'b0;
        rx(1, 8'h35);
        check("pushpop_cnt", int'(fcw[1]), 4);
        check("pushpop_ovf", int'(ovf[1]), 0);
        wait_drain(1, 400);

        // overflow drops the 5th and 6th character
        hold[1] = 1'b1;
        for (int i = 0; i < 6; i++) rx(1, 8'(8'h31 + i));
        for (int i = 0; i < 4; i++) expq[1].push_back(8'(8'h31 + i));
        check("ovf_cnt", int'(fcw[1]), 4);
        check("ovf_flag", int'(ovf[1]), 1);
        hold[1] = 1'b0;
        wait_drain(1, 400);
        check("ovf_drained", int'(fcw[1]), 0);

        // line mode: hold until CR
        rx(2, 8'h61);
        rx(2, 8'h62);
        n = 0;
        repeat (100) begin
            tick();
            if (txs[2]) n++;
        end
        check("lm_hold", n, 0);
        expq[2].push_back(8'h61);
        expq[2].push_back(8'h62);
        expq[2].push_back(8'h0D);
        rx(2, 8'h0D);
        wait_drain(2, 400);
        check("lm_pend", int'(g_dut[2].dut.pend_q), 0);
        check("lm_cnt", int'(fcw[2]), 0);

        // line mode: full without CR flushes
        for (int i = 0; i < 4; i++) begin
            expq[2].push_back(8'(8'h77 + i));
            rx(2, 8'(8'h77 + i));
        end
        tick();
        check("flush_set", int'(g_dut[2].dut.flush_q), 1);
        wait_drain(2, 400);
        check("flush_clr", int'(g_dut[2].dut.flush_q), 0);
        check("flush_cnt", int'(fcw[2]), 0);

        // banner complete, then normal echo and error counting
        wait_drain(0, 2000);
        expq[0].push_back(8'h41);
        rx(0, 8'h41);
        lat = 1;
        while (!txs[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("post_banner_lat", lat, 2);
        wait_drain(0, 100);
        rxe[0] = 1'b1;
        repeat (254) tick();
        rxe[0] = 1'b0;
        check("err_254", int'(errc[0]), 254);
        rxe[0] = 1'b1;
        repeat (46) tick();
        rxe[0] = 1'b0;
        check("err_sat", int'(errc[0]), 255);
        check("err_nopush", int'(fcw[0]), 0);

        // reset in the middle of the banner discards buffered input
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int i = 0; i < 12; i++) expq[0].push_back(ban[i]);
        for (int i = 0; i < 17; i++) rx(0, 8'(8'h50 + i));
        check("ban_cnt", int'(fcw[0]), 16);
        check("ban_ovf", int'(ovf[0]), 1);
        n = 0;
        while (!(txs[0] && txd[0] == 8'h6C) && n < 500) begin
            tick();
            n++;
        end
        check("see_l", int'(n < 500), 1);
        repeat (3) tick();
        rst[0] = 1'b1;
        tick();
        expq[0].delete();
        check("mid_rst_txs", int'(txs[0]), 0);
        rst[0] = 1'b0;
        check("mid_rst_ovf", int'(ovf[0]), 0);
        check("mid_rst_cnt", int'(fcw[0]), 0);
        check("mid_rst_err", int'(errc[0]), 0);
        for (int i = 0; i < 12; i++) expq[0].push_back(ban[i]);
        wait_drain(0, 2000);
        repeat (30) tick();
        for (int g = 0; g < 3; g++) check($sformatf("leftover%0d", g), expq[g].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
